cordic_iter_engine: RTL and testbench



---
 rtl/cordic_iter_engine_if.sv | 30 +++
 rtl/cordic_iter_engine.sv | 264 ++++++++++++++++++++++++++
 tb/tb_cordic_iter_engine.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/cordic_iter_engine_if.sv
// Operand/result handshake bundle for cordic_iter_engine.
// slave = engine side, master = operand issuer / result consumer side.
interface cordic_iter_engine_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] x_in;
  logic [DATA_W-1:0] y_in;
  logic [DATA_W-1:0] z_in;
  logic [1:0]        mode;
  logic              operation;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] x_out;
  logic [DATA_W-1:0] y_out;
  logic [DATA_W-1:0] z_out;
  logic              err_out;
  logic              busy;

  modport slave (
    input  in_valid, x_in, y_in, z_in, mode, operation, out_ready,
    output in_ready, out_valid, x_out, y_out, z_out, err_out, busy
  );

  modport master (
    output in_valid, x_in, y_in, z_in, mode, operation, out_ready,
    input  in_ready, out_valid, x_out, y_out, z_out, err_out, busy
  );
endinterface

// File: rtl/cordic_iter_engine.sv
// Iterative radix-2 CORDIC (circular/linear/hyperbolic, rotation/vectoring), one op in flight.
// Latency = micro-rotations + 1 cycles; define CORDIC_GAIN_COMP_EN for a +1 cycle gain-correction step.
module cordic_iter_engine #(
  parameter int DATA_W = 32,
  parameter int FRAC_W = 16,
  parameter int ITER_N = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  cordic_iter_engine_if.slave   bus
);

  localparam int IDX_W = 6;
  // Angle constants are held at 2^-32 resolution and rounded to FRAC_W.
  localparam int UP_SH = (FRAC_W >= 32) ? FRAC_W - 32 : 0;
  localparam int DN_SH = (FRAC_W < 32) ? 32 - FRAC_W : 0;
  localparam logic [63:0] HALF_LSB = (64'd1 << DN_SH) >> 1;

  localparam logic [1:0] MODE_CIRC = 2'b00;
  localparam logic [1:0] MODE_LIN  = 2'b01;
  localparam logic [1:0] MODE_HYP  = 2'b10;
  localparam logic [1:0] MODE_RSV  = 2'b11;

`ifdef CORDIC_GAIN_COMP_EN
  typedef enum logic [1:0] {S_IDLE, S_ITER, S_COMP, S_HOLD} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_ITER, S_HOLD} state_t;
`endif

  function automatic logic [63:0] round_raw(input logic [63:0] raw);
    return ((raw << UP_SH) + HALF_LSB) >> DN_SH;
  endfunction

  function automatic logic [63:0] atan_raw(input int i);
    case (i)
      0:  return 64'hC90F_DAA2;
      1:  return 64'h76B1_9C16;
      2:  return 64'h3EB6_EBF2;
      3:  return 64'h1FD5_BA9B;
      4:  return 64'h0FFA_ADDC;
      5:  return 64'h07FF_556F;
      6:  return 64'h03FF_EAAB;
      7:  return 64'h01FF_FD55;
      8:  return 64'h00FF_FFAB;
      9:  return 64'h007F_FFF5;
      10: return 64'h003F_FFFF;
      // Beyond here atan(x) is just under x; the -1 keeps exact-half ties rounding down.
      default: return (i <= 32) ? (64'd1 << (32 - i)) - 64'd1 : 64'd0;
    endcase
  endfunction

  function automatic logic [63:0] atanh_raw(input int i);
    case (i)
      1:  return 64'h8C9F_53D5;
      2:  return 64'h4162_BBEA;
      3:  return 64'h202B_1239;
      4:  return 64'h1005_588B;
      5:  return 64'h0800_AAC4;
      6:  return 64'h0400_1555;
      7:  return 64'h0200_02AB;
      8:  return 64'h0100_0055;
      9:  return 64'h0080_000B;
      10: return 64'h0040_0001;
      default: return (i >= 11 && i <= 32) ? (64'd1 << (32 - i)) + 64'd1 : 64'd0;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] angle_of(input logic [1:0] m, input int i);
    logic [DATA_W-1:0] v;
    v = '0;
    case (m)
      MODE_CIRC: v = DATA_W'(round_raw(atan_raw(i)));
      MODE_HYP:  v = DATA_W'(round_raw(atanh_raw(i)));
      MODE_LIN: begin
        if (i <= FRAC_W)          v = DATA_W'(64'd1 << (FRAC_W - i));
        else if (i == FRAC_W + 1) v = DATA_W'(1);
      end
      default:   v = '0;
    endcase
    return v;
  endfunction

  function automatic logic [DATA_W-1:0] asr(input logic [DATA_W-1:0] v, input logic [IDX_W-1:0] s);
    if (int'(s) >= DATA_W) return {DATA_W{v[DATA_W-1]}};
    return $signed(v) >>> s;
  endfunction

  state_t            state_q, state_d;
  logic [DATA_W-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic [1:0]        mode_q, mode_d;
  logic              op_q, op_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              rep_q, rep_d;
  logic              err_q, err_d;
  logic              out_valid_q, out_valid_d;
  logic              in_ready_q, in_ready_d;
  logic              busy_q, busy_d;

  logic              d_pos;
  logic [DATA_W-1:0] x_sh, y_sh, ang;
  logic [DATA_W-1:0] x_step, y_step, z_step;
  logic              hyp, rep_pt, last_idx, iter_done;

  assign d_pos  = op_q ? y_q[DATA_W-1] : ~z_q[DATA_W-1];
  assign x_sh   = asr(x_q, idx_q);
  assign y_sh   = asr(y_q, idx_q);
  assign ang    = angle_of(mode_q, int'(idx_q));
  assign y_step = d_pos ? y_q + x_sh : y_q - x_sh;
  assign z_step = d_pos ? z_q - ang  : z_q + ang;

  always_comb begin
    x_step = x_q;
    case (mode_q)
      MODE_CIRC: x_step = d_pos ? x_q - y_sh : x_q + y_sh;
      MODE_HYP:  x_step = d_pos ? x_q + y_sh : x_q - y_sh;
      default:   x_step = x_q;
    endcase
  end

  // Hyperbolic indices 4, 13, 40 run twice so the sequence still converges.
  assign hyp       = (mode_q == MODE_HYP);
  assign rep_pt    = hyp && !rep_q &&
                     (idx_q == IDX_W'(4) || idx_q == IDX_W'(13) || idx_q == IDX_W'(40));
  assign last_idx  = hyp ? (idx_q == IDX_W'(ITER_N)) : (idx_q == IDX_W'(ITER_N - 1));
  assign iter_done = last_idx && !rep_pt;

`ifdef CORDIC_GAIN_COMP_EN
  localparam int COEF_W = FRAC_W + 3;
  localparam logic [63:0] INV_K_CIRC_RAW = 64'h0000_0000_9B74_EDA8;
  localparam logic [63:0] INV_K_HYP_RAW  = 64'h0000_0001_351E_8720;

  logic signed [COEF_W-1:0]        coef;
  logic signed [DATA_W+COEF_W-1:0] x_prod, y_prod;

  assign coef   = hyp ? COEF_W'(round_raw(INV_K_HYP_RAW)) : COEF_W'(round_raw(INV_K_CIRC_RAW));
  assign x_prod = $signed(x_q) * coef;
  assign y_prod = $signed(y_q) * coef;
`endif

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    z_d         = z_q;
    mode_d      = mode_q;
    op_d        = op_q;
    idx_d       = idx_q;
    rep_d       = rep_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    busy_d      = busy_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          x_d        = bus.x_in;
          y_d        = bus.y_in;
          z_d        = bus.z_in;
          mode_d     = bus.mode;
          op_d       = bus.operation;
          idx_d      = (bus.mode == MODE_HYP) ? IDX_W'(1) : '0;
          rep_d      = 1'b0;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
          if (bus.mode == MODE_RSV) begin
            state_d     = S_HOLD;
            err_d       = 1'b1;
            out_valid_d = 1'b1;
          end else begin
            state_d = S_ITER;
            err_d   = 1'b0;
          end
        end
      end
      S_ITER: begin
        x_d = x_step;
        y_d = y_step;
        z_d = z_step;
        if (rep_pt) begin
          rep_d = 1'b1;
        end else begin
          rep_d = 1'b0;
          idx_d = idx_q + IDX_W'(1);
        end
        if (iter_done) begin
`ifdef CORDIC_GAIN_COMP_EN
          if (mode_q != MODE_LIN) begin
            state_d = S_COMP;
          end else begin
            state_d     = S_HOLD;
            out_valid_d = 1'b1;
          end
`else
          state_d     = S_HOLD;
          out_valid_d = 1'b1;
`endif
        end
      end
`ifdef CORDIC_GAIN_COMP_EN
      S_COMP: begin
        x_d         = DATA_W'(x_prod >>> FRAC_W);
        y_d         = DATA_W'(y_prod >>> FRAC_W);
        state_d     = S_HOLD;
        out_valid_d = 1'b1;
      end
`endif
      S_HOLD: begin
        if (bus.out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
          err_d       = 1'b0;
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        busy_d      = 1'b0;
        err_d       = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      mode_q      <= MODE_CIRC;
      op_q        <= 1'b0;
      idx_q       <= '0;
      rep_q       <= 1'b0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
      mode_q      <= mode_d;
      op_q        <= op_d;
      idx_q       <= idx_d;
      rep_q       <= rep_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.x_out     = x_q;
  assign bus.y_out     = y_q;
  assign bus.z_out     = z_q;
  assign bus.err_out   = err_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_cordic_iter_engine.sv
// Scoreboard bench for cordic_iter_engine: expectations queued at issue, checked at result.
module tb_cordic_iter_engine;

  localparam int DATA_W = 32;

`ifdef CORDIC_GAIN_COMP_EN
  localparam int     LAT_CIRC = 18;
  localparam int     LAT_HYP  = 20;
  localparam longint CR_XY    = 46341;
  localparam longint CV_X     = 92682;
  localparam longint HR_X     = 73900;
  localparam longint HR_Y     = 34151;
`else
  localparam int     LAT_CIRC = 17;
  localparam int     LAT_HYP  = 19;
  localparam longint CR_XY    = 76312;
  localparam longint CV_X     = 152628;
  localparam longint HR_X     = 61200;
  localparam longint HR_Y     = 28282;
`endif
  localparam int LAT_LIN = 17;

  typedef struct {
    longint x, y, z;
    longint tx, ty, tz;
    longint err;
    longint lat;
  } exp_t;

  logic clock;
  logic reset_n;
  int   n_cmp;
  int   n_bad;
  exp_t sb[$];

  cordic_iter_engine_if #(.DATA_W(DATA_W)) ifc ();

  cordic_iter_engine #(.DATA_W(DATA_W), .FRAC_W(16), .ITER_N(16)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (ifc.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input longint obs, input longint exp, input longint tol);
    longint diff;
    n_cmp++;
    diff = obs - exp;
    if (diff < 0) diff = -diff;
    if (diff > tol) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) tol %0d", tag, obs, obs, exp, exp, tol);
    end
  endtask

  task automatic run_op(input string nm, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] z, input logic [1:0] m, input logic op,
                        input longint ex, input longint ey, input longint ez,
                        input longint tx, input longint ty, input longint tz,
                        input longint er, input longint lat_exp, input int hold);
    exp_t e;
    int   w;
    int   lat;
    e.x = ex; e.y = ey; e.z = ez; e.tx = tx; e.ty = ty; e.tz = tz;
    e.err = er; e.lat = lat_exp;
    sb.push_back(e);

    @(negedge clock);
    ifc.x_in = x; ifc.y_in = y; ifc.z_in = z; ifc.mode = m; ifc.operation = op;
    ifc.in_valid = 1'b1;
    w = 0;
    while (!ifc.in_ready && w < 20) begin
      @(negedge clock);
      w++;
    end
    check({nm, "_accept_rdy"}, longint'(ifc.in_ready), 1, 0);
    @(posedge clock);
    #1 ifc.in_valid = 1'b0;
    lat = 1;
    while (!ifc.out_valid && lat < 80) begin
      @(posedge clock);
      #1;
      lat++;
    end

    e = sb.pop_front();
    check({nm, "_out_valid"}, longint'(ifc.out_valid), 1, 0);
    check({nm, "_lat"}, longint'(lat), e.lat, 0);
    check({nm, "_x"}, longint'($signed(ifc.x_out)), e.x, e.tx);
    check({nm, "_y"}, longint'($signed(ifc.y_out)), e.y, e.ty);
    check({nm, "_z"}, longint'($signed(ifc.z_out)), e.z, e.tz);
    check({nm, "_err"}, longint'(ifc.err_out), e.err, 0);
    check({nm, "_busy"}, longint'(ifc.busy), 1, 0);
    check({nm, "_hold_rdy"}, longint'(ifc.in_ready), 0, 0);

    // Hold the result and throw a stray operand at the engine meanwhile.
    for (int k = 0; k < hold; k++) begin
      @(negedge clock);
      ifc.x_in = 32'h7777; ifc.y_in = 32'h1111; ifc.z_in = 32'h2222;
      ifc.mode = 2'b11; ifc.in_valid = 1'b1;
      check({nm, "_bp_vld"}, longint'(ifc.out_valid), 1, 0);
      check({nm, "_bp_rdy"}, longint'(ifc.in_ready), 0, 0);
      check({nm, "_bp_x"}, longint'($signed(ifc.x_out)), e.x, e.tx);
      check({nm, "_bp_z"}, longint'($signed(ifc.z_out)), e.z, e.tz);
    end

    @(negedge clock);
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b1;
    @(posedge clock);
    #1 ifc.out_ready = 1'b0;
    check({nm, "_ret_vld"}, longint'(ifc.out_valid), 0, 0);
    check({nm, "_ret_rdy"}, longint'(ifc.in_ready), 1, 0);
    check({nm, "_ret_busy"}, longint'(ifc.busy), 0, 0);
    check({nm, "_ret_err"}, longint'(ifc.err_out), 0, 0);
  endtask

  initial begin
    int seen;
    n_cmp = 0;
    n_bad = 0;
    reset_n = 1'b0;
    ifc.in_valid = 1'b0; ifc.out_ready = 1'b0;
    ifc.x_in = '0; ifc.y_in = '0; ifc.z_in = '0;
    ifc.mode = 2'b00; ifc.operation = 1'b0;

    #23;
    check("rst_in_ready", longint'(ifc.in_ready), 1, 0);
    check("rst_out_valid", longint'(ifc.out_valid), 0, 0);
    check("rst_busy", longint'(ifc.busy), 0, 0);
    check("rst_err", longint'(ifc.err_out), 0, 0);
    check("rst_x", longint'(ifc.x_out), 0, 0);
    check("rst_y", longint'(ifc.y_out), 0, 0);
    check("rst_z", longint'(ifc.z_out), 0, 0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    check("idle_in_ready", longint'(ifc.in_ready), 1, 0);
    check("idle_out_valid", longint'(ifc.out_valid), 0, 0);

    // name, x, y, z, mode, op, exp x/y/z, tol x/y/z, err, latency, hold cycles
    run_op("crot", 32'h10000, 32'h0, 32'hC90F, 2'b00, 1'b0,
           CR_XY, CR_XY, 0, 16, 16, 16, 0, LAT_CIRC, 0);
    run_op("cvec", 32'h10000, 32'h10000, 32'h0, 2'b00, 1'b1,
           CV_X, 0, 51471, 16, 16, 16, 0, LAT_CIRC, 5);
    run_op("lvec", 32'h20000, 32'h30000, 32'h0, 2'b01, 1'b1,
           32'h20000, 0, 32'h18000, 0, 16, 16, 0, LAT_LIN, 0);
    run_op("lrot", 32'h10000, 32'h0, 32'h8000, 2'b01, 1'b0,
           32'h10000, 32'h8000, 0, 0, 16, 16, 0, LAT_LIN, 2);
    run_op("hrot", 32'h10000, 32'h0, 32'h8000, 2'b10, 1'b0,
           HR_X, HR_Y, 0, 32, 32, 16, 0, LAT_HYP, 0);
    run_op("rsv", 32'h1234, 32'h5678, 32'h9ABC, 2'b11, 1'b0,
           32'h1234, 32'h5678, 32'h9ABC, 0, 0, 0, 1, 1, 3);
    run_op("crot2", 32'h10000, 32'h0, 32'hFFFF36F1, 2'b00, 1'b0,
           CR_XY, -CR_XY, 0, 16, 16, 16, 0, LAT_CIRC, 0);

    // Abort an operation with a reset pulse in its eighth micro-rotation.
    @(negedge clock);
    ifc.x_in = 32'h10000; ifc.y_in = 32'h0; ifc.z_in = 32'hC90F;
    ifc.mode = 2'b00; ifc.operation = 1'b0; ifc.in_valid = 1'b1;
    @(posedge clock);
    #1 ifc.in_valid = 1'b0;
    check("abort_busy", longint'(ifc.busy), 1, 0);
    repeat (7) @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("abort_rst_vld", longint'(ifc.out_valid), 0, 0);
    check("abort_rst_rdy", longint'(ifc.in_ready), 1, 0);
    check("abort_rst_busy", longint'(ifc.busy), 0, 0);
    check("abort_rst_x", longint'(ifc.x_out), 0, 0);
    @(negedge clock);
    reset_n = 1'b1;
    seen = 0;
    repeat (30) begin
      @(posedge clock);
      #1;
      if (ifc.out_valid) seen++;
    end
    check("abort_no_result", longint'(seen), 0, 0);

    run_op("post_abort", 32'h10000, 32'h10000, 32'h0, 2'b00, 1'b1,
           CV_X, 0, 51471, 16, 16, 16, 0, LAT_CIRC, 0);
    check("sb_empty", longint'(sb.size()), 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
